// File: rtl/mem_ctrl.sv
// Word-addressed RAM with a small access sequencer sitting behind the MAR.
// Reads wait READ_LAT cycles and then drive the shared DATA bus until the
// read strobe drops; writes commit one cycle after the request is accepted.
// A request that is still held after completion parks in HOLD so it never
// starts a second access.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a strobe; address/data latched on acceptance
// RD_WAIT   | read latency countdown
// RD_DRIVE  | read word on DATA until r_en drops
// WR_COMMIT | write accepted; array and MDR_OUT update at end of cycle
// HOLD      | access finished or rejected; wait for both strobes low
module mem_ctrl #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int READ_LAT   = 2      // 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ADDR,
    inout  wire  [DATA_W-1:0] DATA,
    input  logic              r_en,
    input  logic              w_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] MDR_OUT
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        RD_DRIVE  = 3'd2,
        WR_COMMIT = 3'd3,
        HOLD      = 3'd4
    } state_t;

    localparam int CNT_W = 4;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    oor_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rd_word;
    logic [DATA_W-1:0]       rd_next;
    logic                    addr_oor;

    // Contents are deliberately not reset.
    logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];

    assign addr_oor = |ADDR[15:DEPTH_LOG2];

    // Out-of-range reads return zero instead of aliasing into the array.
    always_comb begin
        rd_next = '0;
        if (!oor_q) rd_next = mem[idx_q];
    end

    // Bus is only ever driven while the read word is being presented.
    assign DATA = (state == RD_DRIVE) ? rd_word : {DATA_W{1'bz}};

    // Sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            rd_word <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            MDR_OUT <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_en || w_en) begin
                        idx_q <= ADDR[DEPTH_LOG2-1:0];
                        oor_q <= addr_oor;
                        busy  <= 1'b1;
                    end
                    if (r_en && w_en) begin
                        err   <= 1'b1;
                        state <= HOLD;
                    end else if (r_en) begin
                        cnt   <= CNT_W'(READ_LAT - 1);
                        state <= RD_WAIT;
                    end else if (w_en) begin
                        wdata_q <= DATA;
                        done    <= 1'b1;
                        err     <= addr_oor;
                        state   <= WR_COMMIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        rd_word <= rd_next;
                        MDR_OUT <= rd_next;
                        done    <= 1'b1;
                        err     <= oor_q;
                        state   <= RD_DRIVE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if (!r_en) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WR_COMMIT: begin
                    MDR_OUT <= wdata_q;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (!r_en && !w_en) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array write happens on the edge that ends WR_COMMIT; a reset pulled
    // during WR_COMMIT forces IDLE first, so the write never lands.
    always_ff @(posedge clk) begin
        if (state == WR_COMMIT && !oor_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: scripted transactions, a word-level memory model that
// predicts every output cycle by cycle, and a negedge compare process.
module tb_mem_ctrl;

    localparam int DW  = 16;
    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        r_en;
    logic        w_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] mdr;
    wire  [15:0] data_bus;
    logic        tb_drv;
    logic [15:0] tb_val;

    assign data_bus = tb_drv ? tb_val : 16'hzzzz;

    mem_ctrl #(.DATA_W(DW), .DEPTH_LOG2(8), .READ_LAT(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .ADDR    (addr),
        .DATA    (data_bus),
        .r_en    (r_en),
        .w_en    (w_en),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .MDR_OUT (mdr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model of what the outputs must be in the current cycle
    logic        exp_busy, exp_done, exp_err, exp_bus_z;
    logic [15:0] exp_mdr, exp_bus;
    logic [15:0] mdl_mem [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("err",  {31'd0, err},  {31'd0, exp_err});
        chk("mdr",  {16'd0, mdr},  {16'd0, exp_mdr});
        checks++;
        if (exp_bus_z) begin
            if (!(data_bus === 16'hzzzz)) begin
                failures++;
                $display("FAIL bus_release cyc=%0d got=%h want=zzzz", cyc, data_bus);
            end
        end else if (data_bus !== exp_bus) begin
            failures++;
            $display("FAIL bus_value cyc=%0d got=%h want=%h", cyc, data_bus, exp_bus);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_bus_z = 1'b1;
    endtask

    function automatic logic is_oor(input logic [15:0] a);
        return a[15:8] != 8'd0;
    endfunction

    // Write d to a; w_en held for 'extra' cycles beyond acceptance.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int extra);
        logic oor;
        oor = is_oor(a);
        addr = a; tb_val = d; tb_drv = 1'b1; w_en = 1'b1;
        exp_idle();
        exp_bus_z = 1'b0; exp_bus = d;
        tick();                                   // WR_COMMIT
        w_en = (extra > 0); tb_drv = 1'b0; addr = ~a; tb_val = ~d;
        exp_busy = 1'b1; exp_done = 1'b1; exp_err = oor; exp_bus_z = 1'b1;
        tick();                                   // HOLD
        if (!oor) mdl_mem[a[7:0]] = d;
        exp_mdr = d; exp_done = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < extra; i++) tick();
        w_en = 1'b0;
        tick();
        exp_idle();
    endtask

    // Read a; bus held for h cycles. Returns bus/done/err seen in first drive cycle.
    task automatic do_read(input logic [15:0] a, input int h,
                           output logic [15:0] v_seen, output logic done_seen,
                           output logic err_seen);
        logic        oor;
        logic [15:0] v;
        oor = is_oor(a);
        v = oor ? 16'h0000 : mdl_mem[a[7:0]];
        addr = a; r_en = 1'b1;
        exp_idle();
        tick();                                   // RD_WAIT
        addr = ~a;
        exp_busy = 1'b1;
        for (int i = 1; i < LAT; i++) tick();
        tick();                                   // RD_DRIVE
        v_seen = data_bus; done_seen = done; err_seen = err;
        exp_done = 1'b1; exp_err = oor; exp_mdr = v;
        exp_bus_z = 1'b0; exp_bus = v;
        for (int i = 0; i < h; i++) begin
            r_en = (i < h - 1);
            tick();
            exp_done = 1'b0; exp_err = 1'b0;
        end
        exp_idle();
    endtask

    logic [15:0] v;
    logic        dn, er;

    initial begin
        reset = 1'b0; addr = 16'h0; r_en = 1'b0; w_en = 1'b0;
        tb_drv = 1'b0; tb_val = 16'h0;
        exp_idle(); exp_mdr = 16'h0; exp_bus = 16'h0;

        // 1: reset
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mdr",  {16'd0, mdr},  32'd0);
        reset = 1'b1;
        tick();

        // 2: write 0x1234 to 0x0005
        do_write(16'h0005, 16'h1234, 0);
        chk("wr_mdr_lit", {16'd0, mdr}, 32'h1234);
        do_write(16'h0000, 16'hBEEF, 2);
        do_write(16'h00FF, 16'h5A5A, 0);

        // 3: read back
        do_read(16'h0005, 2, v, dn, er);
        chk("rd_data_lit", {16'd0, v}, 32'h1234);
        chk("rd_done_lit", {31'd0, dn}, 32'd1);
        do_read(16'h00FF, 3, v, dn, er);
        chk("rd_top_lit", {16'd0, v}, 32'h5A5A);

        // 4: both strobes
        addr = 16'h0005; r_en = 1'b1; w_en = 1'b1; tb_drv = 1'b1; tb_val = 16'h7777;
        exp_idle(); exp_bus_z = 1'b0; exp_bus = 16'h7777;
        tick();
        tb_drv = 1'b0;
        exp_busy = 1'b1; exp_err = 1'b1; exp_bus_z = 1'b1;
        tick();
        exp_err = 1'b0;
        tick();
        w_en = 1'b0;
        tick();
        r_en = 1'b0;
        tick();
        exp_idle();
        tick();
        do_read(16'h0005, 1, v, dn, er);
        chk("both_unchanged_lit", {16'd0, v}, 32'h1234);

        // 5: out-of-range write, then reads
        do_write(16'h0100, 16'hDEAD, 0);
        do_read(16'h0000, 1, v, dn, er);
        chk("oor_alias_lit", {16'd0, v}, 32'hBEEF);
        do_read(16'h0100, 2, v, dn, er);
        chk("oor_rd_lit", {16'd0, v}, 32'h0000);
        chk("oor_rd_err_lit", {31'd0, er}, 32'd1);

        // 6a: reset during RD_WAIT
        addr = 16'h0005; r_en = 1'b1;
        tick();
        exp_busy = 1'b1;
        #2 reset = 1'b0; r_en = 1'b0;
        #1 exp_idle(); exp_mdr = 16'h0;
        chk("rst_rd_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 6b: reset during WR_COMMIT
        addr = 16'h0005; w_en = 1'b1; tb_drv = 1'b1; tb_val = 16'h9999;
        exp_bus_z = 1'b0; exp_bus = 16'h9999;
        tick();
        w_en = 1'b0; tb_drv = 1'b0;
        exp_busy = 1'b1; exp_done = 1'b1; exp_bus_z = 1'b1;
        #2 reset = 1'b0;
        #1 exp_idle();
        chk("rst_wr_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        do_read(16'h0005, 1, v, dn, er);
        chk("rst_wr_keep_lit", {16'd0, v}, 32'h1234);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
